// File: rtl/conway_gen_scheduler.sv
// Generation scheduler for the Conway accelerator: launches one generation every
// max(rate_div,1) frames and flips the ping-pong buffers only on vsync_start.
// Optional watchdog on the compute phase: define CONWAY_SCHED_WATCHDOG_EN.
module conway_gen_scheduler #(
    parameter int GEN_CNT_W = 16,
    parameter int RATE_W    = 8,
    parameter int WDOG_W    = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_run,
    input  logic                 cmd_stop,
    input  logic                 cmd_step,
    input  logic [RATE_W-1:0]    rate_div,
    input  logic                 vsync_start,
    output logic                 accel_start,
    input  logic                 accel_done,
    output logic                 direction,
    output logic                 swap,
    output logic                 busy,
    output logic                 running,
    output logic [GEN_CNT_W-1:0] gen_count,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 fault
);
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_COMPUTE    = 2'd2,
        S_SWAP_WAIT  = 2'd3
    } state_t;

    localparam logic [GEN_CNT_W-1:0] GEN_ONE  = GEN_CNT_W'(64'd1);
    localparam logic [RATE_W:0]      RATE_ONE = (RATE_W+1)'(64'd1);

    state_t                 state_r, state_s;
    logic [RATE_W-1:0]      frame_cnt_r, frame_cnt_s;
    logic [RATE_W:0]        frame_inc_s, frame_tgt_s;
    logic                   accel_start_r, accel_start_s;
    logic                   direction_r, direction_s;
    logic                   swap_r, swap_s;
    logic                   busy_r, busy_s;
    logic                   running_r, running_s;
    logic [GEN_CNT_W-1:0]   gen_count_r, gen_count_s;
    logic                   overrun_r, overrun_s;
    logic                   wd_expire_s;
    logic                   cmd_ok_s;
    logic                   run_req_s;
    logic                   step_req_s;
    logic                   run_hold_s;

`ifdef CONWAY_SCHED_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'((64'd1 << WDOG_W) - 64'd2);
    localparam logic [WDOG_W-1:0] WD_ONE  = WDOG_W'(64'd1);

    logic [WDOG_W-1:0] wd_cnt_r, wd_cnt_s;
    logic              fault_r, fault_s;

    // Expiry fires in the cycle whose increment would reach 2^WDOG_W-1; done still wins.
    assign wd_expire_s = (state_r == S_COMPUTE) && (wd_cnt_r == WD_LAST) && !accel_done;
    assign cmd_ok_s    = ~fault_r;
    assign fault       = fault_r;

    // Watchdog counter restarts at every launch and advances only while computing.
    always_comb begin
        if (accel_start_s) begin
            wd_cnt_s = {WDOG_W{1'b0}};
        end else if (state_r == S_COMPUTE) begin
            wd_cnt_s = wd_cnt_r + WD_ONE;
        end else begin
            wd_cnt_s = wd_cnt_r;
        end
        if (wd_expire_s) begin
            fault_s = 1'b1;
        end else begin
            fault_s = fault_r;
        end
    end

    // Watchdog registers; fault stays set until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt_r <= {WDOG_W{1'b0}};
            fault_r  <= 1'b0;
        end else begin
            wd_cnt_r <= wd_cnt_s;
            fault_r  <= fault_s;
        end
    end
`else
    assign wd_expire_s = 1'b0;
    assign cmd_ok_s    = 1'b1;
    assign fault       = 1'b0;
`endif

    // Stop beats run; a faulted scheduler accepts neither run nor step.
    assign run_req_s   = cmd_run & ~cmd_stop & cmd_ok_s;
    assign step_req_s  = cmd_step & cmd_ok_s;
    assign run_hold_s  = cmd_stop ? 1'b0 : (run_req_s ? 1'b1 : running_r);
    assign frame_inc_s = {1'b0, frame_cnt_r} + RATE_ONE;
    assign frame_tgt_s = (rate_div == {RATE_W{1'b0}}) ? RATE_ONE : {1'b0, rate_div};

    // Next-state and next-output logic for the generation sequencer.
    always_comb begin
        state_s       = state_r;
        frame_cnt_s   = frame_cnt_r;
        accel_start_s = 1'b0;
        direction_s   = direction_r;
        swap_s        = 1'b0;
        busy_s        = busy_r;
        running_s     = running_r;
        gen_count_s   = gen_count_r;
        if (clr_overrun) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end

        case (state_r)
            S_IDLE: begin
                if (run_req_s) begin
                    running_s = 1'b1;
                    state_s   = S_WAIT_FRAME;
                end else if (step_req_s) begin
                    running_s = 1'b0;
                    state_s   = S_WAIT_FRAME;
                end else begin
                    state_s   = S_IDLE;
                end
            end
            S_WAIT_FRAME: begin
                running_s = run_hold_s;
                if (cmd_stop) begin
                    frame_cnt_s = {RATE_W{1'b0}};
                    state_s     = S_IDLE;
                end else if (vsync_start) begin
                    // >= keeps a lowered rate_div from stranding the count above it
                    if (frame_inc_s >= frame_tgt_s) begin
                        frame_cnt_s   = {RATE_W{1'b0}};
                        accel_start_s = 1'b1;
                        busy_s        = 1'b1;
                        state_s       = S_COMPUTE;
                    end else begin
                        frame_cnt_s   = frame_inc_s[RATE_W-1:0];
                    end
                end else begin
                    state_s = S_WAIT_FRAME;
                end
            end
            S_COMPUTE: begin
                running_s = run_hold_s;
                if (accel_done) begin
                    busy_s = 1'b0;
                    if (vsync_start) begin
                        direction_s = ~direction_r;
                        swap_s      = 1'b1;
                        gen_count_s = gen_count_r + GEN_ONE;
                        state_s     = run_hold_s ? S_WAIT_FRAME : S_IDLE;
                    end else begin
                        state_s     = S_SWAP_WAIT;
                    end
                end else if (wd_expire_s) begin
                    busy_s    = 1'b0;
                    running_s = 1'b0;
                    state_s   = S_IDLE;
                end else if (vsync_start) begin
                    overrun_s = 1'b1;
                end else begin
                    state_s   = S_COMPUTE;
                end
            end
            S_SWAP_WAIT: begin
                running_s = run_hold_s;
                if (vsync_start) begin
                    direction_s = ~direction_r;
                    swap_s      = 1'b1;
                    gen_count_s = gen_count_r + GEN_ONE;
                    state_s     = run_hold_s ? S_WAIT_FRAME : S_IDLE;
                end else begin
                    state_s     = S_SWAP_WAIT;
                end
            end
            default: begin
                busy_s    = 1'b0;
                running_s = 1'b0;
                state_s   = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            frame_cnt_r   <= {RATE_W{1'b0}};
            accel_start_r <= 1'b0;
            direction_r   <= 1'b0;
            swap_r        <= 1'b0;
            busy_r        <= 1'b0;
            running_r     <= 1'b0;
            gen_count_r   <= {GEN_CNT_W{1'b0}};
            overrun_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            frame_cnt_r   <= frame_cnt_s;
            accel_start_r <= accel_start_s;
            direction_r   <= direction_s;
            swap_r        <= swap_s;
            busy_r        <= busy_s;
            running_r     <= running_s;
            gen_count_r   <= gen_count_s;
            overrun_r     <= overrun_s;
        end
    end

    assign accel_start = accel_start_r;
    assign direction   = direction_r;
    assign swap        = swap_r;
    assign busy        = busy_r;
    assign running     = running_r;
    assign gen_count   = gen_count_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_conway_gen_scheduler.sv
// Directed-plus-random bench for conway_gen_scheduler; expectations come from
// generation/frame bookkeeping (swaps counted, direction = parity of swaps).
module tb_conway_gen_scheduler;
    localparam int GEN_CNT_W = 16;
    localparam int RATE_W    = 8;
    localparam int WDOG_W    = 4;
`ifdef CONWAY_SCHED_WATCHDOG_EN
    localparam int LAT_MAX   = 10;
    localparam int STEP_LAT  = 10;
`else
    localparam int LAT_MAX   = 40;
    localparam int STEP_LAT  = 499;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cmd_run, cmd_stop, cmd_step;
    logic [RATE_W-1:0]    rate_div;
    logic                 vsync_start, accel_done, clr_overrun;
    logic                 accel_start, direction, swap, busy, running, overrun, fault;
    logic [GEN_CNT_W-1:0] gen_count;

    int vectors     = 0;
    int miscompares = 0;
    int starts_seen = 0;
    int swaps_seen  = 0;
    int exp_gen     = 0;
    logic exp_fault = 1'b0;
    int s0, w0;

    conway_gen_scheduler #(.GEN_CNT_W(GEN_CNT_W), .RATE_W(RATE_W), .WDOG_W(WDOG_W)) dut (
        .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_stop(cmd_stop), .cmd_step(cmd_step),
        .rate_div(rate_div), .vsync_start(vsync_start), .accel_start(accel_start),
        .accel_done(accel_done), .direction(direction), .swap(swap), .busy(busy),
        .running(running), .gen_count(gen_count), .overrun(overrun),
        .clr_overrun(clr_overrun), .fault(fault)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (accel_start === 1'b1) starts_seen = starts_seen + 1;
        if (swap === 1'b1) swaps_seen = swaps_seen + 1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic r, input logic st, input logic sp,
                         input logic vs, input logic dn, input logic co);
        cmd_run = r; cmd_stop = st; cmd_step = sp;
        vsync_start = vs; accel_done = dn; clr_overrun = co;
        cyc(1);
        cmd_run = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
        vsync_start = 1'b0; accel_done = 1'b0; clr_overrun = 1'b0;
    endtask

    task automatic vsync();
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic done();
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_all(input string tag, input logic eb, input logic er, input logic eo);
        chk({tag, ":busy"}, 32'(busy), 32'(eb));
        chk({tag, ":running"}, 32'(running), 32'(er));
        chk({tag, ":overrun"}, 32'(overrun), 32'(eo));
        chk({tag, ":gen_count"}, 32'(gen_count), 32'(exp_gen % (1 << GEN_CNT_W)));
        chk({tag, ":direction"}, 32'(direction), 32'(exp_gen % 2));
        chk({tag, ":fault"}, 32'(fault), 32'(exp_fault));
    endtask

    // One free-running generation: start on the max(r,1)-th vsync, swap on the next one.
    task automatic free_gen(input int r);
        int eff, sb, wb;
        eff = (r == 0) ? 1 : r;
        rate_div = r[RATE_W-1:0];
        sb = starts_seen;
        wb = swaps_seen;
        for (int k = 1; k <= eff; k++) begin
            cyc($urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0) pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            vsync();
            chk("gen_start_pulse", 32'(accel_start), 32'(k == eff));
        end
        chk("gen_busy_set", 32'(busy), 32'd1);
        cyc($urandom_range(2, LAT_MAX));
        done();
        chk("gen_busy_clr", 32'(busy), 32'd0);
        chk("gen_no_early_swap", 32'(swap), 32'd0);
        cyc($urandom_range(1, 30));
        vsync();
        exp_gen++;
        chk("gen_swap", 32'(swap), 32'd1);
        check_all("gen", 1'b0, 1'b1, 1'b0);
        cyc(1);
        chk("gen_start_count", 32'(starts_seen - sb), 32'd1);
        chk("gen_swap_count", 32'(swaps_seen - wb), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        cmd_run = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
        vsync_start = 1'b0; accel_done = 1'b0; clr_overrun = 1'b0;
        rate_div = 8'd1;
        cyc(3);
        reset = 1'b1;
        check_all("reset", 1'b0, 1'b0, 1'b0);
        chk("reset:accel_start", 32'(accel_start), 32'd0);
        chk("reset:swap", 32'(swap), 32'd0);

        // Reset in the middle of a compute abandons it without a swap.
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vsync();
        chk("mid:start", 32'(accel_start), 32'd1);
        chk("mid:busy", 32'(busy), 32'd1);
        w0 = swaps_seen;
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        check_all("mid_reset", 1'b0, 1'b0, 1'b0);
        chk("mid_reset:accel_start", 32'(accel_start), 32'd0);
        done();
        vsync();
        cyc(2);
        chk("mid_reset:no_swap", 32'(swaps_seen - w0), 32'd0);
        check_all("stray_done", 1'b0, 1'b0, 1'b0);

        // Single step with a long compute and a late vsync.
        s0 = starts_seen;
        w0 = swaps_seen;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("step:running", 32'(running), 32'd0);
        cyc(3);
        vsync();
        chk("step:start", 32'(accel_start), 32'd1);
        cyc(STEP_LAT);
        done();
        chk("step:busy_clr", 32'(busy), 32'd0);
        cyc(1000);
        vsync();
        exp_gen++;
        chk("step:swap", 32'(swap), 32'd1);
        check_all("step", 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            cyc(10);
            vsync();
        end
        chk("step:one_start", 32'(starts_seen - s0), 32'd1);
        chk("step:one_swap", 32'(swaps_seen - w0), 32'd1);

        // Free run at rate 3 from a clean reset: four generations bring direction back to 0.
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        exp_gen = 0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("run:running", 32'(running), 32'd1);
        repeat (4) free_gen(3);
        chk("run4:gen_count", 32'(gen_count), 32'd4);
        chk("run4:direction", 32'(direction), 32'd0);

        // Random rates, including 0 (treated as 1).
        repeat (6) free_gen($urandom_range(0, 4));

        // Overrun: vsync while computing, swap waits for the following vsync.
        rate_div = 8'd1;
        cyc(3);
        vsync();
        chk("ovr:start", 32'(accel_start), 32'd1);
        cyc(5);
        vsync();
        chk("ovr:set", 32'(overrun), 32'd1);
        chk("ovr:no_swap", 32'(swap), 32'd0);
        cyc(5);
        done();
        chk("ovr:busy_clr", 32'(busy), 32'd0);
        cyc(5);
        vsync();
        exp_gen++;
        chk("ovr:swap", 32'(swap), 32'd1);
        check_all("ovr", 1'b0, 1'b1, 1'b1);
        cyc(3);
        vsync();
        chk("ovr2:start", 32'(accel_start), 32'd1);
        cyc(3);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ovr:set_beats_clr", 32'(overrun), 32'd1);
        cyc(2);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr:cleared", 32'(overrun), 32'd0);
        cyc(4);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_gen++;
        chk("done_vsync:swap", 32'(swap), 32'd1);
        check_all("done_vsync", 1'b0, 1'b1, 1'b0);

        // Stop during compute: running drops at once, generation still swaps.
        cyc(3);
        vsync();
        chk("stop:start", 32'(accel_start), 32'd1);
        cyc(2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stop:running", 32'(running), 32'd0);
        chk("stop:busy", 32'(busy), 32'd1);
        cyc(5);
        done();
        cyc(5);
        vsync();
        exp_gen++;
        chk("stop:swap", 32'(swap), 32'd1);
        s0 = starts_seen;
        repeat (3) begin
            cyc(4);
            vsync();
        end
        chk("stop:no_more_starts", 32'(starts_seen - s0), 32'd0);
        check_all("stop", 1'b0, 1'b0, 1'b0);

        // Run and stop together from IDLE: stop wins.
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("runstop:running", 32'(running), 32'd0);
        vsync();
        vsync();
        cyc(1);
        chk("runstop:no_start", 32'(starts_seen - s0), 32'd0);

        // Run and step together: run wins; then stop while waiting for a frame.
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("runstep:running", 32'(running), 32'd1);
        cyc(2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("waitstop:running", 32'(running), 32'd0);
        vsync();
        vsync();
        cyc(1);
        chk("waitstop:no_start", 32'(starts_seen - s0), 32'd0);

        // Run during a step converts it to free running.
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vsync();
        chk("step_run:start", 32'(accel_start), 32'd1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("step_run:running", 32'(running), 32'd1);
        cyc(5);
        done();
        cyc(5);
        vsync();
        exp_gen++;
        chk("step_run:swap", 32'(swap), 32'd1);
        cyc(5);
        vsync();
        chk("step_run:continues", 32'(accel_start), 32'd1);
        cyc(5);
        done();
        cyc(3);
        vsync();
        exp_gen++;
        check_all("step_run", 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("step_run_stop", 1'b0, 1'b0, 1'b0);

`ifdef CONWAY_SCHED_WATCHDOG_EN
        // Watchdog: no done, fault 15 cycles after entering COMPUTE.
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vsync();
        chk("wd:start", 32'(accel_start), 32'd1);
        cyc(14);
        chk("wd:not_yet", 32'(fault), 32'd0);
        cyc(1);
        exp_fault = 1'b1;
        check_all("wd", 1'b0, 1'b0, 1'b0);
        s0 = starts_seen;
        w0 = swaps_seen;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vsync();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vsync();
        cyc(1);
        chk("wd:cmds_ignored", 32'(starts_seen - s0), 32'd0);
        chk("wd:no_swap", 32'(swaps_seen - w0), 32'd0);
        check_all("wd_after", 1'b0, 1'b0, 1'b0);
`else
        // Without the watchdog a long compute simply waits.
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vsync();
        cyc(200);
        check_all("nowd_wait", 1'b1, 1'b0, 1'b0);
        done();
        vsync();
        exp_gen++;
        check_all("nowd_done", 1'b0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/conway_gen_scheduler.md
Name: conway_gen_scheduler

Overview:
- Sequences the Conway accelerator one generation at a time.
- Decides when a generation starts, waits for it to complete, and swaps the ping-pong buffer direction only at the VGA vertical-sync boundary, so the display never tears.
- Takes run/stop/single-step commands from the host register interface and sits between that interface, the VGA controller and the accelerator core.

Parameters:
- GEN_CNT_W, 16, width of the generation counter.
- RATE_W, 8, width of the frames-per-generation divider.
- WDOG_W, 20, watchdog timeout exponent; timeout is 2^WDOG_W-1 cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  active-low reset, synchronous to clk.
- cmd_run  in  1  one-cycle pulse: start free-running generations.
- cmd_stop  in  1  one-cycle pulse: stop after the current generation.
- cmd_step  in  1  one-cycle pulse: compute exactly one generation.
- rate_div  in  RATE_W  vsync pulses per generation; 0 is treated as 1.
- vsync_start  in  1  one-cycle pulse from the VGA controller at the start of vertical blank.
- accel_start  out  1  one-cycle pulse: accelerator begins a generation.
- accel_done  in  1  one-cycle pulse: accelerator has written the last word.
- direction  out  1  0 = accelerator reads m1 and writes m2, VGA displays m1; 1 = the opposite.
- swap  out  1  one-cycle pulse in the cycle direction toggles.
- busy  out  1  high from accel_start until accel_done.
- running  out  1  free-run mode active.
- gen_count  out  GEN_CNT_W  number of completed, swapped generations.
- overrun  out  1  sticky: a frame boundary occurred mid-compute.
- clr_overrun  in  1  pulse that clears overrun.
- fault  out  1  sticky watchdog fault; tied 0 without the optional feature.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; direction=0, gen_count=0, running=0, busy=0, overrun=0, fault=0, accel_start=0, swap=0, frame_cnt=0. Reset mid-compute abandons the generation with no swap.
- All outputs are registered.
- State IDLE:
  - cmd_run -> running=1, go to WAIT_FRAME.
  - cmd_step -> go to WAIT_FRAME with running=0.
  - cmd_stop is ignored.
  - If cmd_run and cmd_step arrive together, run wins.
- State WAIT_FRAME:
  - Each vsync_start increments frame_cnt.
  - When the incremented value reaches max(rate_div,1): frame_cnt=0, accel_start=1 for one cycle, busy=1, go to COMPUTE.
  - cmd_stop -> running=0, go to IDLE with frame_cnt=0.
- State COMPUTE:
  - vsync_start without accel_done -> overrun=1.
  - accel_done -> busy=0, go to SWAP_WAIT.
  - accel_done and vsync_start in the same cycle -> swap is performed in that cycle, as in SWAP_WAIT; overrun is not set.
- State SWAP_WAIT:
  - On vsync_start: direction toggles, swap=1 for one cycle, gen_count increments (wraps from all-ones to 0).
  - Next state is WAIT_FRAME if running, else IDLE.
  - This vsync does not count toward frame_cnt.
- Stop handling: cmd_stop in COMPUTE or SWAP_WAIT clears running immediately; the in-flight generation still completes and swaps, then the block goes to IDLE.
- cmd_step while running is ignored. cmd_run during a step sets running=1 and the block continues free-running.
- cmd_run and cmd_stop in the same cycle: stop wins.
- overrun: set has priority over a simultaneous clr_overrun.
- accel_done outside COMPUTE is ignored.
- rate_div is sampled at each vsync_start; changing it mid-count takes effect on the next compare.

Optional Feature:
- Macro CONWAY_SCHED_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in COMPUTE, cleared on entry.
  - If it reaches 2^WDOG_W-1 without accel_done: fault=1 (sticky until reset), busy=0, running=0, go to IDLE, no swap, gen_count unchanged.
  - While fault=1, cmd_run and cmd_step are ignored.
- Undefined: no counter; fault is constant 0; COMPUTE waits indefinitely.

Test Plan:
- Reset held low 3 cycles mid-COMPUTE -> all outputs at reset values; direction=0; no swap pulse.
- cmd_step, rate_div=1, accel_done 500 cycles after accel_start, next vsync 1000 cycles later -> exactly one accel_start; swap at that vsync; direction=1; gen_count=1; state IDLE.
- cmd_run, rate_div=3, done always well within the frame -> accel_start on every 3rd vsync after the swap; gen_count=4 after 4 generations; direction returns to 0.
- cmd_run, accel_done held off past one vsync -> overrun=1; swap at the first vsync after done. Then clr_overrun together with a new overrun event -> overrun stays 1.
- cmd_stop during COMPUTE -> running=0 at once; generation completes and swaps; no further accel_start. cmd_run+cmd_stop in the same cycle from IDLE -> stays IDLE.
- With CONWAY_SCHED_WATCHDOG_EN and WDOG_W=4, accel_done never asserted -> fault=1 at 15 cycles after entering COMPUTE; IDLE; gen_count unchanged; subsequent cmd_step ignored.
